// File: rtl/memory_arbiter.sv
// Arbitrates a dcache and an icache onto one RAM port, with a sticky watchdog flag for slow RAM.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants when both caches request together.
module memory_arbiter #(
  parameter int unsigned WATCHDOG = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        ramerr
);

  localparam int unsigned CNT_W = 8;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_dreq;
  logic             w_access;
  logic             w_owner_req;
  logic             w_grant_d;
  logic [CNT_W:0]   w_cnt_inc;

  assign w_dreq      = dREN | dWEN;
  assign w_access    = (ramstate == RAM_ACCESS);
  assign w_owner_req = (r_state == D_ACC) ? w_dreq : iREN;
  assign w_cnt_inc   = {1'b0, r_cnt} + (CNT_W+1)'(1);

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = data side held the most recent grant
  logic r_last_d;

  assign w_grant_d = w_dreq & (~iREN | ~r_last_d);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_last_d <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_grant_d) begin
        r_last_d <= 1'b1;
      end else if (iREN) begin
        r_last_d <= 1'b0;
      end
    end
  end
`else
  assign w_grant_d = w_dreq;
`endif

  // Grant FSM, wait counter and sticky watchdog flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      ramerr  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state <= D_ACC;
            r_cnt   <= '0;
          end else if (iREN) begin
            r_state <= I_ACC;
            r_cnt   <= '0;
          end
        end
        D_ACC, I_ACC: begin
          if (!w_access && (r_cnt != CNT_MAX)) begin
            r_cnt <= w_cnt_inc[CNT_W-1:0];
            if (32'(w_cnt_inc) == WATCHDOG) begin
              ramerr <= 1'b1;
            end
          end
          if (!w_owner_req || w_access) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // RAM strobes and handshakes follow the granted side in the same cycle
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    dwait    = 1'b1;
    iwait    = 1'b1;
    case (r_state)
      D_ACC: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = ~w_access;
      end
      I_ACC: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        iwait   = ~w_access;
      end
      default: ;
    endcase
  end

  assign dload = ramload;
  assign iload = ramload;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed vector table, watchdog sequence, randomized run vs. transaction model.
module tb_memory_arbiter;

  localparam int unsigned WD = 64;
  localparam logic [1:0] S_FREE = 2'd0, S_BUSY = 2'd1, S_ACC = 2'd2, S_ERR = 2'd3;

  logic        CLK = 1'b0;
  logic        RST, dREN, dWEN, iREN;
  logic [31:0] daddr, dstore, iaddr, ramload;
  logic [1:0]  ramstate;
  logic        dwait, iwait, ramREN, ramWEN, ramerr;
  logic [31:0] dload, iload, ramaddr, ramstore;

  always #5 CLK = ~CLK;

  memory_arbiter #(.WATCHDOG(WD)) dut (
    .CLK(CLK), .RST(RST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ramerr(ramerr)
  );

  typedef logic [132:0] obs_t;

  typedef struct {
    logic rst, dren, dwen;
    logic [31:0] da, ds;
    logic ire;
    logic [31:0] ia;
    logic [1:0] rs;
    logic [31:0] rl;
    logic e_ren, e_wen;
    logic [31:0] e_addr, e_store;
    logic e_dw, e_iw;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: who owns the RAM port, how long it has waited, error flag
  int m_owner = 0;  // 0 none, 1 dcache, 2 icache
  int m_wait  = 0;
  bit m_err   = 1'b0;
  bit m_last_d = 1'b0;

  function automatic obs_t pack(input logic ren, wen, input logic [31:0] a, s,
                                input logic dw, iw, input logic [31:0] dl, il, input logic er);
    return {ren, wen, a, s, dw, iw, dl, il, er};
  endfunction

  function automatic obs_t dut_obs();
    return pack(ramREN, ramWEN, ramaddr, ramstore, dwait, iwait, dload, iload, ramerr);
  endfunction

  function automatic obs_t model_out();
    bit acc;
    acc = (ramstate == S_ACC);
    if (m_owner == 1)
      return pack(dREN & ~dWEN, dWEN, daddr, dstore, ~acc, 1'b1, ramload, ramload, m_err);
    else if (m_owner == 2)
      return pack(1'b1, 1'b0, iaddr, 32'h0, 1'b1, ~acc, ramload, ramload, m_err);
    return pack(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, ramload, ramload, m_err);
  endfunction

  task automatic model_step();
    bit want_d, pick_d, req;
    if (RST) begin
      m_owner = 0; m_wait = 0; m_err = 1'b0; m_last_d = 1'b0;
    end else if (m_owner == 0) begin
      want_d = dREN | dWEN;
`ifdef ARB_ROUND_ROBIN_EN
      pick_d = want_d && (!iREN || !m_last_d);
`else
      pick_d = want_d;
`endif
      if (pick_d) begin
        m_owner = 1; m_wait = 0; m_last_d = 1'b1;
      end else if (iREN) begin
        m_owner = 2; m_wait = 0; m_last_d = 1'b0;
      end
    end else begin
      req = (m_owner == 1) ? (dREN | dWEN) : iREN;
      if (ramstate != S_ACC && m_wait < 255) begin
        m_wait++;
        if (m_wait == int'(WD)) m_err = 1'b1;
      end
      if (!req || ramstate == S_ACC) m_owner = 0;
    end
  endtask

  task automatic check(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic advance();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  function automatic vec_t mk(input logic rst, dren, dwen, input logic [31:0] da, ds,
                              input logic ire, input logic [31:0] ia,
                              input logic [1:0] rs, input logic [31:0] rl,
                              input logic eren, ewen, input logic [31:0] ea, es,
                              input logic edw, eiw);
    vec_t v;
    v.rst = rst; v.dren = dren; v.dwen = dwen; v.da = da; v.ds = ds;
    v.ire = ire; v.ia = ia; v.rs = rs; v.rl = rl;
    v.e_ren = eren; v.e_wen = ewen; v.e_addr = ea; v.e_store = es;
    v.e_dw = edw; v.e_iw = eiw;
    return v;
  endfunction

  vec_t tbl[$];
  int   busy_run;

  initial begin
    RST = 1'b1; dREN = 0; dWEN = 0; iREN = 0;
    daddr = 0; dstore = 0; iaddr = 0; ramload = 0; ramstate = S_FREE;
    advance();
    advance();

    // rst dR dW daddr dstore iR iaddr rs rload | REN WEN addr store dwait iwait
    tbl.push_back(mk(1,0,0,32'h0,  32'h0,0,32'h44,S_FREE,32'h0,        0,0,32'h0,  32'h0,1,1));
    tbl.push_back(mk(0,1,0,32'h100,32'h0,0,32'h44,S_BUSY,32'h0,        0,0,32'h0,  32'h0,1,1));
    tbl.push_back(mk(0,1,0,32'h100,32'h0,0,32'h44,S_BUSY,32'h0,        1,0,32'h100,32'h0,1,1));
    tbl.push_back(mk(0,1,0,32'h100,32'h0,0,32'h44,S_BUSY,32'h0,        1,0,32'h100,32'h0,1,1));
    tbl.push_back(mk(0,1,0,32'h100,32'h0,0,32'h44,S_BUSY,32'h0,        1,0,32'h100,32'h0,1,1));
    tbl.push_back(mk(0,1,0,32'h100,32'h0,0,32'h44,S_ACC, 32'hDEADBEEF, 1,0,32'h100,32'h0,0,1));
    tbl.push_back(mk(0,0,0,32'h100,32'h0,0,32'h44,S_FREE,32'h0,        0,0,32'h0,  32'h0,1,1));
    // write wins when both strobes are high
    tbl.push_back(mk(0,1,1,32'h200,32'h12345678,0,32'h44,S_FREE,32'h0, 0,0,32'h0,  32'h0,1,1));
    tbl.push_back(mk(0,1,1,32'h200,32'h12345678,0,32'h44,S_BUSY,32'h0, 0,1,32'h200,32'h12345678,1,1));
    tbl.push_back(mk(0,1,1,32'h200,32'h12345678,0,32'h44,S_ACC, 32'h5, 0,1,32'h200,32'h12345678,0,1));
    tbl.push_back(mk(0,0,0,32'h200,32'h12345678,0,32'h44,S_FREE,32'h0, 0,0,32'h0,  32'h0,1,1));
    // both requesters pending
    tbl.push_back(mk(1,0,0,32'h0,  32'h0,0,32'h0,  S_FREE,32'h0,       0,0,32'h0,  32'h0,1,1));
    tbl.push_back(mk(0,1,0,32'h300,32'h0,1,32'h400,S_FREE,32'h0,       0,0,32'h0,  32'h0,1,1));
    tbl.push_back(mk(0,1,0,32'h300,32'h0,1,32'h400,S_BUSY,32'h0,       1,0,32'h300,32'h0,1,1));
    tbl.push_back(mk(0,1,0,32'h300,32'h0,1,32'h400,S_ACC, 32'h11,      1,0,32'h300,32'h0,0,1));
    tbl.push_back(mk(0,1,0,32'h300,32'h0,1,32'h400,S_FREE,32'h0,       0,0,32'h0,  32'h0,1,1));
`ifdef ARB_ROUND_ROBIN_EN
    tbl.push_back(mk(0,1,0,32'h300,32'h0,1,32'h400,S_ACC, 32'h22,      1,0,32'h400,32'h0,1,0));
`else
    tbl.push_back(mk(0,1,0,32'h300,32'h0,1,32'h400,S_ACC, 32'h22,      1,0,32'h300,32'h0,0,1));
`endif
    tbl.push_back(mk(0,0,0,32'h300,32'h0,1,32'h400,S_FREE,32'h0,       0,0,32'h0,  32'h0,1,1));
    tbl.push_back(mk(0,0,0,32'h300,32'h0,1,32'h400,S_BUSY,32'h0,       1,0,32'h400,32'h0,1,1));
    tbl.push_back(mk(0,0,0,32'h300,32'h0,1,32'h400,S_ACC, 32'h33,      1,0,32'h400,32'h0,1,0));
    tbl.push_back(mk(0,0,0,32'h300,32'h0,0,32'h400,S_FREE,32'h0,       0,0,32'h0,  32'h0,1,1));
    // reset in the middle of a data access
    tbl.push_back(mk(0,1,0,32'h500,32'h0,0,32'h0,  S_BUSY,32'h0,       0,0,32'h0,  32'h0,1,1));
    tbl.push_back(mk(0,1,0,32'h500,32'h0,0,32'h0,  S_BUSY,32'h0,       1,0,32'h500,32'h0,1,1));
    tbl.push_back(mk(1,1,0,32'h500,32'h0,0,32'h0,  S_BUSY,32'h0,       1,0,32'h500,32'h0,1,1));
    tbl.push_back(mk(0,1,0,32'h500,32'h0,0,32'h0,  S_BUSY,32'h0,       0,0,32'h0,  32'h0,1,1));
    tbl.push_back(mk(0,1,0,32'h500,32'h0,0,32'h0,  S_BUSY,32'h0,       1,0,32'h500,32'h0,1,1));
    tbl.push_back(mk(0,1,0,32'h500,32'h0,0,32'h0,  S_ACC, 32'h44,      1,0,32'h500,32'h0,0,1));
    tbl.push_back(mk(0,0,0,32'h500,32'h0,0,32'h0,  S_FREE,32'h0,       0,0,32'h0,  32'h0,1,1));
    // ERROR is a retry: no completion until ACCESS
    tbl.push_back(mk(0,0,0,32'h0,  32'h0,1,32'h600,S_FREE,32'h0,       0,0,32'h0,  32'h0,1,1));
    tbl.push_back(mk(0,0,0,32'h0,  32'h0,1,32'h600,S_ERR, 32'h0,       1,0,32'h600,32'h0,1,1));
    tbl.push_back(mk(0,0,0,32'h0,  32'h0,1,32'h600,S_ERR, 32'h0,       1,0,32'h600,32'h0,1,1));
    tbl.push_back(mk(0,0,0,32'h0,  32'h0,1,32'h600,S_ACC, 32'h600D,    1,0,32'h600,32'h0,1,0));
    tbl.push_back(mk(0,0,0,32'h0,  32'h0,0,32'h600,S_FREE,32'h0,       0,0,32'h0,  32'h0,1,1));
    // icache withdraws its request: abandoned without completion
    tbl.push_back(mk(0,0,0,32'h0,  32'h0,1,32'h700,S_BUSY,32'h0,       0,0,32'h0,  32'h0,1,1));
    tbl.push_back(mk(0,0,0,32'h0,  32'h0,1,32'h700,S_BUSY,32'h0,       1,0,32'h700,32'h0,1,1));
    tbl.push_back(mk(0,0,0,32'h0,  32'h0,0,32'h700,S_BUSY,32'h0,       1,0,32'h700,32'h0,1,1));
    tbl.push_back(mk(0,0,0,32'h0,  32'h0,0,32'h700,S_ACC, 32'h0,       0,0,32'h0,  32'h0,1,1));

    foreach (tbl[i]) begin
      RST = tbl[i].rst; dREN = tbl[i].dren; dWEN = tbl[i].dwen;
      daddr = tbl[i].da; dstore = tbl[i].ds; iREN = tbl[i].ire; iaddr = tbl[i].ia;
      ramstate = tbl[i].rs; ramload = tbl[i].rl;
      #2;
      check($sformatf("vec%0d", i), dut_obs(),
            pack(tbl[i].e_ren, tbl[i].e_wen, tbl[i].e_addr, tbl[i].e_store,
                 tbl[i].e_dw, tbl[i].e_iw, tbl[i].rl, tbl[i].rl, 1'b0));
      advance();
    end

    // Watchdog: icache waits 70 cycles, flag sticks through completion until reset
    RST = 1'b1; dREN = 0; dWEN = 0; iREN = 0; ramstate = S_FREE; ramload = 0;
    advance();
    RST = 1'b0; iREN = 1'b1; iaddr = 32'h800; ramstate = S_BUSY;
    #2; check("wd_idle", dut_obs(), model_out());
    advance();
    for (int k = 1; k <= 70; k++) begin
      #2;
      check_bit($sformatf("wd_err_k%0d", k), ramerr, logic'(k >= 65));
      if (k % 10 == 0) check($sformatf("wd_obs_k%0d", k), dut_obs(), model_out());
      advance();
    end
    ramstate = S_ACC; ramload = 32'hCAFE0001;
    #2;
    check_bit("wd_iwait_done", iwait, 1'b0);
    check_bit("wd_err_at_access", ramerr, 1'b1);
    advance();
    iREN = 1'b0; ramstate = S_FREE;
    #2; check_bit("wd_err_sticky", ramerr, 1'b1);
    advance();
    RST = 1'b1;
    #2; check_bit("wd_err_before_rst_edge", ramerr, 1'b1);
    advance();
    RST = 1'b0;
    #2; check_bit("wd_err_cleared", ramerr, 1'b0);
    advance();

    // Randomized traffic against the transaction model
    busy_run = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        dREN = 1'($urandom_range(0, 1));
        dWEN = ($urandom_range(0, 3) == 0);
        iREN = 1'($urandom_range(0, 1));
      end
      daddr = $urandom; dstore = $urandom; iaddr = $urandom; ramload = $urandom;
      if (busy_run == 0 && $urandom_range(0, 599) == 0) busy_run = 80;
      if (busy_run > 0) begin
        ramstate = S_BUSY;
        busy_run--;
      end else begin
        ramstate = 2'($urandom_range(0, 3));
      end
      RST = ($urandom_range(0, 299) == 0);
      #2;
      check($sformatf("rand%0d", n), dut_obs(), model_out());
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
